// File: rtl/cache_pkg.sv
// Shared types and constants for the cache backing-memory responder.
// Defines line geometry, responder FSM states and the line-base helper.
// No logic here; pure declarations.
package cache_pkg;

  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 32;
  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_W    = $clog2(LINE_WORDS);
  localparam int WORD_ADDR_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE
  } state_t;

  // Word index of the first word in the line holding byte address addr.
  function automatic logic [WORD_ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W+2], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/line_fill_responder_ram.sv
// Word-addressed line storage: one write port, one registered read port.
// Latency: read data appears the cycle after re is asserted.
// Backpressure: none; every enabled access completes in one cycle.
module line_fill_responder_ram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; the output register clears on reset so rd_data reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_fill_responder.sv
// Backing-memory responder: one line fill or write-back at a time, critical word first.
// Latency: first beat LATENCY cycles after request accept; done pulses after the last beat.
// Backpressure: req_ready only in IDLE; write beats stall on wr_valid low; fill beats cannot stall.
module line_fill_responder #(
  parameter int ADDR_W     = cache_pkg::ADDR_W,
  parameter int DATA_W     = cache_pkg::DATA_W,
  parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
  parameter int LATENCY    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(LINE_WORDS)-1:0] rd_beat,
  output logic                          done
);

  import cache_pkg::state_t;
  import cache_pkg::line_base;

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int WA_W  = ADDR_W - 2;
  localparam int LAT_W = $clog2(LATENCY + 1);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_t             state, state_n;
  logic [LAT_W-1:0]   lat_cnt;
  logic [OFF_W-1:0]   beat;
  logic [OFF_W-1:0]   start_off;
  logic [WA_W-1:0]    base;
  logic               we_q;
  logic               accept;

  logic               ram_re, ram_we;
  logic [OFF_W-1:0]   rd_off, wr_off;
  logic [WA_W-1:0]    ram_raddr, ram_waddr;

  assign accept   = req_valid && req_ready;
  assign rd_valid = (state == cache_pkg::RBURST);
  assign wr_ready = (state == cache_pkg::WBURST);
  assign done     = (state == cache_pkg::DONE);

  // Offsets wrap inside the line; base is fixed for the burst so no carry escapes.
  assign wr_off    = start_off + beat;
  assign ram_waddr = {base[WA_W-1:OFF_W], wr_off};
  assign ram_raddr = {base[WA_W-1:OFF_W], rd_off};

  // Next state plus RAM strobes; reads are issued one cycle ahead of the beat they feed.
  always_comb begin
    state_n = state;
    ram_re  = 1'b0;
    ram_we  = 1'b0;
    rd_off  = start_off + beat + OFF_W'(1);
    case (state)
      cache_pkg::IDLE: begin
        if (accept) state_n = cache_pkg::WAIT;
      end
      cache_pkg::WAIT: begin
        if (lat_cnt == '0) begin
          if (we_q) begin
            state_n = cache_pkg::WBURST;
          end else begin
            state_n = cache_pkg::RBURST;
            ram_re  = 1'b1;
            rd_off  = start_off;
          end
        end
      end
      cache_pkg::RBURST: begin
        if (beat == LAST_BEAT) state_n = cache_pkg::DONE;
        else                   ram_re  = 1'b1;
      end
      cache_pkg::WBURST: begin
        if (wr_valid) begin
          ram_we = 1'b1;
          if (beat == LAST_BEAT) state_n = cache_pkg::DONE;
        end
      end
      cache_pkg::DONE: state_n = cache_pkg::IDLE;
      default:         state_n = cache_pkg::IDLE;
    endcase
  end

  // State, request latch, latency and beat counters, registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= cache_pkg::IDLE;
      req_ready <= 1'b0;
      we_q      <= 1'b0;
      base      <= '0;
      start_off <= '0;
      lat_cnt   <= '0;
      beat      <= '0;
      rd_beat   <= '0;
    end else begin
      state     <= state_n;
      // Registered so ready rises one edge after reset and stays low through DONE.
      req_ready <= (state_n == cache_pkg::IDLE);
      if (ram_re) rd_beat <= rd_off;
      case (state)
        cache_pkg::IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            base      <= line_base(req_addr);
            start_off <= req_addr[OFF_W+1:2];
            lat_cnt   <= LAT_W'(LATENCY - 1);
            beat      <= '0;
          end
        end
        cache_pkg::WAIT: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
        end
        cache_pkg::RBURST: begin
          if (beat != LAST_BEAT) beat <= beat + OFF_W'(1);
        end
        cache_pkg::WBURST: begin
          if (wr_valid) beat <= beat + OFF_W'(1);
        end
        default: ;
      endcase
    end
  end

  line_fill_responder_ram #(
    .AW(WA_W),
    .DW(DATA_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(wr_data),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: fills, wrapped fills, stalled write-backs,
// request back-pressure, mid-burst reset and the top line of the address space.
// Outputs are sampled 1 time unit after each rising edge.
module tb_line_fill_responder;

  localparam int LATENCY = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [10:0] req_addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [1:0]  rd_beat;
  logic        done;

  int n_total = 0;
  int n_pass  = 0;

  line_fill_responder #(
    .ADDR_W(11), .DATA_W(32), .LINE_WORDS(4), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_beat(rd_beat), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_ready_wait"}, 32'(req_ready), 32'd1);
  endtask

  // d0..d3 are the expected data in beat order (critical word first).
  task automatic fill(input string tag, input logic [10:0] addr,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    int s;
    d = '{d0, d1, d2, d3};
    s = int'(addr[3:2]);
    wait_ready(tag);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    tick();
    req_valid = 1'b0;
    chk({tag, "_ready_low"}, 32'(req_ready), 32'd0);
    for (int i = 1; i < LATENCY; i++) begin
      tick();
      chk($sformatf("%s_wait%0d_rd_valid", tag, i), 32'(rd_valid), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("%s_b%0d_rd_valid", tag, k), 32'(rd_valid), 32'd1);
      chk($sformatf("%s_b%0d_rd_beat", tag, k), 32'(rd_beat), 32'((s + k) % 4));
      chk($sformatf("%s_b%0d_rd_data", tag, k), rd_data, d[k]);
      chk($sformatf("%s_b%0d_done", tag, k), 32'(done), 32'd0);
    end
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    chk({tag, "_rd_valid_off"}, 32'(rd_valid), 32'd0);
    chk({tag, "_ready_in_done"}, 32'(req_ready), 32'd0);
    tick();
    chk({tag, "_done_clear"}, 32'(done), 32'd0);
    chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  // d0..d3 are written in beat order; stall_at = beats taken before the stall gap.
  task automatic wback(input string tag, input logic [10:0] addr,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3,
                       input int stall_at, input int stall_cycles);
    logic [31:0] d [4];
    int k, cyc, left;
    logic taken;
    d = '{d0, d1, d2, d3};
    wait_ready(tag);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
    tick();
    req_valid = 1'b0;
    k = 0; cyc = 0; left = stall_cycles;
    while (k < 4 && cyc < 40) begin
      if (k == stall_at && left > 0) begin
        wr_valid = 1'b0;
        left--;
      end else begin
        wr_valid = 1'b1;
        wr_data  = d[k];
      end
      taken = wr_ready && wr_valid;
      tick();
      if (taken) k++;
      cyc++;
    end
    wr_valid = 1'b0;
    chk({tag, "_beats_taken"}, 32'(k), 32'd4);
    chk({tag, "_wr_ready_drop"}, 32'(wr_ready), 32'd0);
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    tick();
    chk({tag, "_done_clear"}, 32'(done), 32'd0);
  endtask

  initial begin
    int acc, dn;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    wr_data = '0; wr_valid = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_beat", 32'(rd_beat), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
    tick();
    chk("rel_ready_after_edge", 32'(req_ready), 32'd1);

    // Preload line 0x100 and fill it in order, with junk on wr_valid outside WBURST.
    wback("pre100", 11'h100, 32'hA000_00A0, 32'hA000_00A1, 32'hA000_00A2, 32'hA000_00A3, -1, 0);
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    fill("fill100", 11'h100, 32'hA000_00A0, 32'hA000_00A1, 32'hA000_00A2, 32'hA000_00A3);
    wr_valid = 1'b0;

    // Critical word at offset 3 wraps to 0.
    fill("fill10c", 11'h10C, 32'hA000_00A3, 32'hA000_00A0, 32'hA000_00A1, 32'hA000_00A2);

    // Stalled write-back starting at offset 2, then fill from offset 0.
    wback("wb208", 11'h208, 32'h11, 32'h22, 32'h33, 32'h44, 2, 2);
    fill("fill200", 11'h200, 32'h33, 32'h44, 32'h11, 32'h22);

    // req_valid held high across two bursts: one accept per 9-cycle burst.
    wait_ready("bp");
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h100;
    acc = 0; dn = 0;
    for (int i = 0; i < 18; i++) begin
      if (req_ready) acc++;
      if (done) dn++;
      tick();
    end
    req_valid = 1'b0;
    chk("bp_accepts", 32'(acc), 32'd2);
    chk("bp_dones", 32'(dn), 32'd2);
    chk("bp_ready_after", 32'(req_ready), 32'd1);

    // Reset during read beat 2.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h100;
    tick();
    req_valid = 1'b0;
    repeat (LATENCY + 2) tick();
    chk("mid_beat2_valid", 32'(rd_valid), 32'd1);
    chk("mid_beat2_beat", 32'(rd_beat), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rd_data", rd_data, 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fill("postrst100", 11'h100, 32'hA000_00A0, 32'hA000_00A1, 32'hA000_00A2, 32'hA000_00A3);

    // Write-back immediately followed by a fill of the same line.
    wback("raw104", 11'h104, 32'hB1, 32'hB2, 32'hB3, 32'hB0, -1, 0);
    fill("raw100", 11'h100, 32'hB0, 32'hB1, 32'hB2, 32'hB3);

    // Top line: offsets wrap within 0x7F0..0x7FF, line 0 untouched.
    wback("pre000", 11'h000, 32'hC0, 32'hC1, 32'hC2, 32'hC3, -1, 0);
    wback("wb7fc", 11'h7FC, 32'hF3, 32'hF0, 32'hF1, 32'hF2, -1, 0);
    fill("fill7f0", 11'h7F0, 32'hF0, 32'hF1, 32'hF2, 32'hF3);
    fill("fill7fc", 11'h7FC, 32'hF3, 32'hF0, 32'hF1, 32'hF2);
    fill("fill000", 11'h000, 32'hC0, 32'hC1, 32'hC2, 32'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
